// File: rtl/dm_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - state_t    : arbiter FSM states (IDLE, HOST, PE)
//   - *_LSB      : bit offsets of the address fields inside an instruction word
//                  (raddr0 at [7:0], raddr1 at [15:8], waddr at [23:16])
// -----------------------------------------------------------------------------
package dm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOST = 2'd1,
        ST_PE   = 2'd2
    } state_t;

    localparam int RADDR0_LSB = 0;
    localparam int RADDR1_LSB = 8;
    localparam int WADDR_LSB  = 16;

endpackage : dm_arbiter_pkg

// File: rtl/dm_rr_arb.sv
// -----------------------------------------------------------------------------
// dm_rr_arb
// Two-way request arbiter between the host loader and the PE.
// Build option: macro DM_ARB_RR_EN
//   defined   : round-robin; a one-bit pointer remembers who has priority next
//               (reset value: host) and flips on every granted request.
//   undefined : fixed priority, host always wins; no pointer register.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_req_h, i_req_p host / PE requests
//   i_upd            grants are live this cycle (pointer may advance)
//   o_gnt_h, o_gnt_p one-hot (or zero) grant
// -----------------------------------------------------------------------------
module dm_rr_arb (
    input  logic clk,
    input  logic rst,
    input  logic i_req_h,
    input  logic i_req_p,
    input  logic i_upd,
    output logic o_gnt_h,
    output logic o_gnt_p
);

`ifdef DM_ARB_RR_EN
    logic r_ptr_host;   // 1: host wins a tie, 0: PE wins a tie

    always_comb begin
        o_gnt_h = i_req_h & (r_ptr_host | ~i_req_p);
        o_gnt_p = i_req_p & (~r_ptr_host | ~i_req_h);
    end

    // A grant always transfers (ready is the grant, valid is the request), so
    // the pointer moves away from whoever was just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_host <= 1'b1;
        end else if (i_upd && o_gnt_h) begin
            r_ptr_host <= 1'b0;
        end else if (i_upd && o_gnt_p) begin
            r_ptr_host <= 1'b1;
        end
    end
`else
    // Stateless in this build; clock, reset and update are intentionally idle.
    logic w_unused;
    assign w_unused = clk | rst | i_upd;

    assign o_gnt_h = i_req_h;
    assign o_gnt_p = i_req_p & ~i_req_h;
`endif

endmodule : dm_rr_arb

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Arbitrates data-memory access between a host loader (write bursts) and a PE
// (single-beat read/write), registering the chosen request onto the memory
// port and producing a read-valid two cycles after a PE read beat.
// Build option: macro DM_ARB_RR_EN selects round-robin instead of host-first
// arbitration (see dm_rr_arb).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   h_valid/h_ready             host write handshake
//   h_waddr, h_wdata, h_last    host address, data, final beat of burst
//   p_valid/p_ready             PE access handshake
//   p_inst, p_wren, p_rden      PE address instruction and enables
//   p_wdata                     PE write data
//   p_rvalid                    read data from memory is valid for the PE
//   dm_wren, dm_rden            registered memory enables
//   dm_inst, dm_wdata           registered memory instruction / write data
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int DM_ADDR_WIDTH = 8,
    parameter int INST_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     h_valid,
    output logic                     h_ready,
    input  logic [DM_ADDR_WIDTH-1:0] h_waddr,
    input  logic [DATA_WIDTH-1:0]    h_wdata,
    input  logic                     h_last,
    input  logic                     p_valid,
    output logic                     p_ready,
    input  logic [INST_WIDTH-1:0]    p_inst,
    input  logic                     p_wren,
    input  logic                     p_rden,
    input  logic [DATA_WIDTH-1:0]    p_wdata,
    output logic                     p_rvalid,
    output logic                     dm_wren,
    output logic                     dm_rden,
    output logic [INST_WIDTH-1:0]    dm_inst,
    output logic [DATA_WIDTH-1:0]    dm_wdata
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    w_gnt_h;
    logic                    w_gnt_p;
    logic                    w_h_xfer;
    logic                    w_p_xfer;
    logic [INST_WIDTH-1:0]   w_host_inst;
    logic                    r_dm_wren;
    logic                    r_dm_rden;
    logic [INST_WIDTH-1:0]   r_dm_inst;
    logic [DATA_WIDTH-1:0]   r_dm_wdata;
    logic                    r_p_rvalid;

    dm_rr_arb u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req_h (h_valid),
        .i_req_p (p_valid),
        .i_upd   (r_state == ST_IDLE),
        .o_gnt_h (w_gnt_h),
        .o_gnt_p (w_gnt_p)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        h_ready     = 1'b0;
        p_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                h_ready = w_gnt_h;
                p_ready = w_gnt_p;
                // The granting beat itself transfers in IDLE; a single-beat
                // burst (h_last on the first beat) therefore never enters HOST.
                if (w_gnt_h && !h_last) begin
                    w_state_nxt = ST_HOST;
                end else if (w_gnt_p) begin
                    w_state_nxt = ST_PE;
                end
            end
            ST_HOST: begin
                h_ready = 1'b1;
                if (h_valid && h_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PE: begin
                // One dead cycle after a PE beat; the PE is re-arbitrated in IDLE.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // The grant is combinational from live requests, so reset must mask it.
        if (rst) begin
            h_ready = 1'b0;
            p_ready = 1'b0;
        end
    end

    assign w_h_xfer = h_valid & h_ready;
    assign w_p_xfer = p_valid & p_ready;

    // Host beats are pure writes: both read-address fields stay zero.
    always_comb begin
        w_host_inst                                 = '0;
        w_host_inst[RADDR0_LSB +: DM_ADDR_WIDTH]    = '0;
        w_host_inst[RADDR1_LSB +: DM_ADDR_WIDTH]    = '0;
        w_host_inst[WADDR_LSB  +: DM_ADDR_WIDTH]    = h_waddr;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dm_wren  <= 1'b0;
            r_dm_rden  <= 1'b0;
            r_dm_inst  <= '0;
            r_dm_wdata <= '0;
            r_p_rvalid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // dm_rden is only ever set by a PE read beat, so delaying it one
            // more cycle gives the two-cycle read-valid. Reset clears both
            // stages, so an in-flight read is dropped.
            r_p_rvalid <= r_dm_rden;
            if (w_h_xfer) begin
                r_dm_wren  <= 1'b1;
                r_dm_rden  <= 1'b0;
                r_dm_inst  <= w_host_inst;
                r_dm_wdata <= h_wdata;
            end else if (w_p_xfer) begin
                r_dm_wren  <= p_wren;
                r_dm_rden  <= p_rden;
                r_dm_inst  <= p_inst;
                r_dm_wdata <= p_wdata;
            end else begin
                // Idle cycle: enables drop, address/data hold.
                r_dm_wren  <= 1'b0;
                r_dm_rden  <= 1'b0;
            end
        end
    end

    assign dm_wren  = r_dm_wren;
    assign dm_rden  = r_dm_rden;
    assign dm_inst  = r_dm_inst;
    assign dm_wdata = r_dm_wdata;
    assign p_rvalid = r_p_rvalid;

endmodule : dm_arbiter

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized run
// compared against a rule-level reference model. A small synchronous memory
// model sits on the dm_* port so read-before-write behaviour is visible.
// Follows the DM_ARB_RR_EN build option of the design.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;

`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        h_valid, h_ready, h_last;
    logic [7:0]  h_waddr;
    logic [15:0] h_wdata;
    logic        p_valid, p_ready, p_wren, p_rden, p_rvalid;
    logic [31:0] p_inst;
    logic [15:0] p_wdata;
    logic        dm_wren, dm_rden;
    logic [31:0] dm_inst;
    logic [15:0] dm_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [256];
    logic [15:0] rdata0;

    dm_arbiter #(
        .DATA_WIDTH    (16),
        .DM_ADDR_WIDTH (8),
        .INST_WIDTH    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .h_valid  (h_valid),
        .h_ready  (h_ready),
        .h_waddr  (h_waddr),
        .h_wdata  (h_wdata),
        .h_last   (h_last),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .p_inst   (p_inst),
        .p_wren   (p_wren),
        .p_rden   (p_rden),
        .p_wdata  (p_wdata),
        .p_rvalid (p_rvalid),
        .dm_wren  (dm_wren),
        .dm_rden  (dm_rden),
        .dm_inst  (dm_inst),
        .dm_wdata (dm_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data lands in the same cycle p_rvalid is high.
    always @(posedge clk) begin
        if (dm_rden) rdata0 <= mem[dm_inst[7:0]];
        if (dm_wren) mem[dm_inst[23:16]] <= dm_wdata;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic idle_inputs();
        h_valid = 1'b0;
        h_last  = 1'b0;
        p_valid = 1'b0;
        p_wren  = 1'b0;
        p_rden  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        h_valid = 1'b1; h_waddr = 8'h33; h_wdata = 16'hBEEF; h_last = 1'b1;
        p_valid = 1'b1; p_inst = 32'h1; p_wren = 1'b1; p_rden = 1'b1; p_wdata = 16'h1;
        @(negedge clk); #1;
        n_tests++;
        if ({h_ready, p_ready} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", {h_ready, p_ready});
        end
        n_tests++;
        if ({dm_wren, dm_rden, p_rvalid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_enables: got %b want 000", {dm_wren, dm_rden, p_rvalid});
        end
        n_tests++;
        if ({dm_inst, dm_wdata} !== 48'h0) begin
            n_fail++; $display("FAIL reset_inst_wdata: got %h/%h want 0/0", dm_inst, dm_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({h_ready, p_ready} !== 2'b10) begin
            n_fail++; $display("FAIL reset_release_grant: got %b want 10", {h_ready, p_ready});
        end
        @(posedge clk); #1;
        n_tests++;
        if (dm_wren !== 1'b1 || dm_rden !== 1'b0 || dm_inst !== 32'h0033_0000 || dm_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL reset_first_host_beat: got wren=%b rden=%b inst=%h wdata=%h want 1 0 00330000 beef",
                     dm_wren, dm_rden, dm_inst, dm_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_host_burst();
        logic [31:0] exp_inst;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            h_valid = 1'b1; h_waddr = 8'h10 + 8'(b); h_wdata = 16'hA1 + 16'(b); h_last = (b == 2);
            p_valid = 1'b1; p_inst = 32'h0000_0007; p_rden = 1'b1; p_wren = 1'b0;
            #1;
            n_tests++;
            if ({h_ready, p_ready} !== 2'b10) begin
                n_fail++; $display("FAIL burst_ready beat%0d: got %b want 10", b, {h_ready, p_ready});
            end
            @(posedge clk); #1;
            exp_inst = {8'h00, 8'h10 + 8'(b), 16'h0000};
            n_tests++;
            if (dm_wren !== 1'b1 || dm_rden !== 1'b0 || dm_inst !== exp_inst || dm_wdata !== 16'hA1 + 16'(b)) begin
                n_fail++;
                $display("FAIL burst_write beat%0d: got wren=%b rden=%b inst=%h wdata=%h want 1 0 %h %h",
                         b, dm_wren, dm_rden, dm_inst, dm_wdata, exp_inst, 16'hA1 + 16'(b));
            end
        end
        @(negedge clk);
        h_valid = 1'b0; h_last = 1'b0;
        #1;
        n_tests++;
        if ({h_ready, p_ready} !== 2'b01) begin
            n_fail++; $display("FAIL burst_pe_after: got %b want 01", {h_ready, p_ready});
        end
        @(posedge clk); #1;
        n_tests++;
        if (dm_wren !== 1'b0 || dm_rden !== 1'b1 || dm_inst !== 32'h0000_0007) begin
            n_fail++;
            $display("FAIL burst_pe_beat: got wren=%b rden=%b inst=%h want 0 1 00000007", dm_wren, dm_rden, dm_inst);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_pe_read();
        do_reset();
        @(negedge clk);
        p_valid = 1'b1; p_rden = 1'b1; p_wren = 1'b0; p_inst = 32'h0000_0504; p_wdata = 16'h0;
        #1;
        n_tests++;
        if ({h_ready, p_ready} !== 2'b01) begin
            n_fail++; $display("FAIL pe_read_ready: got %b want 01", {h_ready, p_ready});
        end
        @(posedge clk); #1;
        n_tests++;
        if (dm_rden !== 1'b1 || dm_wren !== 1'b0 || dm_inst !== 32'h0000_0504 || p_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL pe_read_beat: got rden=%b wren=%b inst=%h rvalid=%b want 1 0 00000504 0",
                     dm_rden, dm_wren, dm_inst, p_rvalid);
        end
        // Keep requesting (as a no-op beat) to see the every-other-cycle acceptance.
        @(negedge clk);
        p_rden = 1'b0;
        #1;
        n_tests++;
        if (p_ready !== 1'b0) begin
            n_fail++; $display("FAIL pe_b2b_stall: got p_ready=%b want 0", p_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (p_rvalid !== 1'b1 || dm_rden !== 1'b0) begin
            n_fail++; $display("FAIL pe_read_rvalid: got rvalid=%b rden=%b want 1 0", p_rvalid, dm_rden);
        end
        @(negedge clk); #1;
        n_tests++;
        if (p_ready !== 1'b1) begin
            n_fail++; $display("FAIL pe_b2b_accept: got p_ready=%b want 1", p_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (p_rvalid !== 1'b0 || dm_inst !== 32'h0000_0504) begin
            n_fail++; $display("FAIL pe_rvalid_single: got rvalid=%b inst=%h want 0 00000504", p_rvalid, dm_inst);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_arb_alternation();
        bit grants [4];
        int n_g = 0;
        do_reset();
        @(negedge clk);
        h_valid = 1'b1; h_last = 1'b1; h_waddr = 8'h40; h_wdata = 16'h0;
        p_valid = 1'b1; p_wren = 1'b0; p_rden = 1'b0; p_inst = 32'h0;
        for (int c = 0; c < 12 && n_g < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            if (h_ready === 1'b1 || p_ready === 1'b1) begin
                grants[n_g] = (h_ready === 1'b1);
                n_g++;
            end
        end
        idle_inputs();
        n_tests++;
        if (n_g != 4) begin
            n_fail++; $display("FAIL arb_grant_count: got %0d grants want 4", n_g);
        end
        for (int k = 0; k < n_g; k++) begin
            n_tests++;
            if (grants[k] !== (RR ? (k % 2 == 0) : 1'b1)) begin
                n_fail++;
                $display("FAIL arb_grant%0d: got host=%b want host=%b", k, grants[k], RR ? (k % 2 == 0) : 1'b1);
            end
        end
    endtask

    task automatic test_rw_same_addr();
        bit seen;
        do_reset();
        @(negedge clk);
        h_valid = 1'b1; h_waddr = 8'h20; h_wdata = 16'h1111; h_last = 1'b1;
        @(negedge clk);
        idle_inputs();
        p_valid = 1'b1; p_inst = 32'h0020_0020; p_wren = 1'b1; p_rden = 1'b1; p_wdata = 16'h2222;
        #1;
        n_tests++;
        if (p_ready !== 1'b1) begin
            n_fail++; $display("FAIL rw_ready: got p_ready=%b want 1", p_ready);
        end
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            if (p_rvalid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rw_old_rvalid: got no p_rvalid within 4 cycles want 1");
        end else if (rdata0 !== 16'h1111) begin
            n_fail++; $display("FAIL rw_old_data: got %h want 1111", rdata0);
        end
        @(negedge clk);
        p_valid = 1'b1; p_inst = 32'h0000_0020; p_wren = 1'b0; p_rden = 1'b1;
        @(negedge clk);
        idle_inputs();
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge clk); #1;
            if (p_rvalid === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++; $display("FAIL rw_new_rvalid: got no p_rvalid within 4 cycles want 1");
        end else if (rdata0 !== 16'h2222) begin
            n_fail++; $display("FAIL rw_new_data: got %h want 2222", rdata0);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        @(negedge clk);
        p_valid = 1'b1; p_rden = 1'b1; p_wren = 1'b0; p_inst = 32'h0000_0504;
        @(posedge clk); #1;
        n_tests++;
        if (dm_rden !== 1'b1) begin
            n_fail++; $display("FAIL rif_handshake: got dm_rden=%b want 1", dm_rden);
        end
        idle_inputs();
        rst = 1'b1;
        #1;
        n_tests++;
        if (dm_rden !== 1'b0) begin
            n_fail++; $display("FAIL rif_rden_clear: got dm_rden=%b want 0", dm_rden);
        end
        @(negedge clk);
        rst = 1'b0;
        p_valid = 1'b1; p_rden = 1'b0; p_wren = 1'b0;
        #1;
        n_tests++;
        if (p_ready !== 1'b1) begin
            n_fail++; $display("FAIL rif_idle: got p_ready=%b want 1", p_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) idle_inputs();
            n_tests++;
            if (p_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL rif_no_rvalid cycle%0d: got %b want 0", i, p_rvalid);
            end
        end
        // Reset in the middle of a host burst must not leave the FSM in HOST.
        @(negedge clk);
        h_valid = 1'b1; h_last = 1'b0; h_waddr = 8'h50; h_wdata = 16'h5;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p_valid = 1'b1;
        #1;
        n_tests++;
        if ({h_ready, p_ready} !== 2'b01) begin
            n_fail++; $display("FAIL rif_burst_abandon: got %b want 01", {h_ready, p_ready});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_idle_hold();
        do_reset();
        @(negedge clk);
        p_valid = 1'b1; p_wren = 1'b1; p_rden = 1'b0; p_inst = 32'h00AB_CDEF; p_wdata = 16'h5A5A;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({dm_wren, dm_rden, p_rvalid, dm_inst, dm_wdata} !== {3'b000, 32'h00AB_CDEF, 16'h5A5A}) begin
                n_fail++;
                $display("FAIL idle_hold cycle%0d: got en=%b%b%b inst=%h wdata=%h want 000 00abcdef 5a5a",
                         i, dm_wren, dm_rden, p_rvalid, dm_inst, dm_wdata);
            end
        end
    endtask

    // Reference model works from the access rules: a host burst owns the port
    // until its last beat, a PE beat is followed by one dead cycle, and ties in
    // an open cycle go to the host (fixed) or to whoever was not served last.
    task automatic test_random();
        bit          m_burst, m_pe_hold, m_host_prio;
        bit          eh, ep, hx, px;
        bit          e_wren, e_rden, e_rv;
        logic [31:0] e_inst;
        logic [15:0] e_wdata;
        do_reset();
        m_burst = 1'b0; m_pe_hold = 1'b0; m_host_prio = 1'b1;
        e_wren = 1'b0; e_rden = 1'b0; e_rv = 1'b0; e_inst = '0; e_wdata = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            h_valid = 1'($urandom_range(0, 1));
            h_waddr = 8'($urandom);
            h_wdata = 16'($urandom);
            h_last  = ($urandom_range(0, 2) == 0);
            p_valid = 1'($urandom_range(0, 1));
            p_inst  = $urandom;
            p_wren  = 1'($urandom_range(0, 1));
            p_rden  = 1'($urandom_range(0, 1));
            p_wdata = 16'($urandom);
            #1;
            if (m_burst) begin
                eh = 1'b1; ep = 1'b0;
            end else if (m_pe_hold) begin
                eh = 1'b0; ep = 1'b0;
            end else if (h_valid && p_valid) begin
                eh = RR ? m_host_prio : 1'b1;
                ep = !eh;
            end else begin
                eh = h_valid; ep = p_valid;
            end
            n_tests++;
            if ({h_ready, p_ready} !== {eh, ep}) begin
                n_fail++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, {h_ready, p_ready}, {eh, ep});
            end
            hx = h_valid && eh;
            px = p_valid && ep;
            e_rv = e_rden;
            if (hx) begin
                e_wren = 1'b1; e_rden = 1'b0; e_inst = {8'h00, h_waddr, 16'h0000}; e_wdata = h_wdata;
            end else if (px) begin
                e_wren = p_wren; e_rden = p_rden; e_inst = p_inst; e_wdata = p_wdata;
            end else begin
                e_wren = 1'b0; e_rden = 1'b0;
            end
            m_pe_hold = px;
            if (hx) begin
                m_host_prio = 1'b0;
                m_burst = !h_last;
            end
            if (px) m_host_prio = 1'b1;
            @(posedge clk); #1;
            n_tests++;
            if ({dm_wren, dm_rden, p_rvalid} !== {e_wren, e_rden, e_rv}) begin
                n_fail++;
                $display("FAIL rand_enables cyc%0d: got %b want %b", cyc, {dm_wren, dm_rden, p_rvalid}, {e_wren, e_rden, e_rv});
            end
            n_tests++;
            if ({dm_inst, dm_wdata} !== {e_inst, e_wdata}) begin
                n_fail++;
                $display("FAIL rand_data cyc%0d: got %h/%h want %h/%h", cyc, dm_inst, dm_wdata, e_inst, e_wdata);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        h_waddr = '0; h_wdata = '0; p_inst = '0; p_wdata = '0;
        test_reset();
        test_host_burst();
        test_pe_read();
        test_arb_alternation();
        test_rw_same_addr();
        test_reset_in_flight();
        test_idle_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dm_arbiter
